// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes, data-memory freeze,
// sticky halt on memory timeout, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_memread,
    input  logic [4:0]       id_dst,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               ex_valid_q, ex_memread_q;
    logic [4:0]         ex_dst_q;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               load_use, taken, flush_evt, stall_evt;

    assign load_use = id_valid & ex_valid_q & ex_memread_q & (ex_dst_q != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_dst_q)) | (id_uses_rt & (id_rt == ex_dst_q)));
    assign taken    = ex_valid_q & ex_branch_taken;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StRun: begin
                if (dmem_busy) begin
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end
            end
            StMemWait: begin
                if (!dmem_busy) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StHalt: ;
            default: state_d = StRun;
        endcase
    end

    // Output logic: reset forces bubbles everywhere, then freeze > taken > load-use > jump
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        flush_evt   = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (state_q == StHalt || dmem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (id_valid && id_jump) begin
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
        end
    end

    assign mem_timeout = (state_q == StHalt);
    assign stall_evt   = !pc_write && (state_q != StHalt);

    // Shadow of ID/EX; a flushed slot enters as a bubble so the load-use stall lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_memread_q <= 1'b0;
            ex_dst_q     <= 5'd0;
        end else if (idex_write) begin
            ex_valid_q   <= id_valid & ~idex_flush;
            ex_memread_q <= id_memread;
            ex_dst_q     <= id_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (flush_evt && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the hazard/freeze/halt rules.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_memread, id_jump;
    logic       ex_branch_taken, dmem_busy;
    logic [4:0] id_rs, id_rt, id_dst;

    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_flush, memwb_flush, mem_timeout;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write;
    logic        s_ifid_flush, s_idex_flush, s_memwb_flush, s_mem_timeout;
    logic [3:0]  s_stall_count, s_flush_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_memread(id_memread),
        .id_dst(id_dst), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .exmem_write(exmem_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .memwb_flush(memwb_flush), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_memread(id_memread),
        .id_dst(id_dst), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_write(s_idex_write), .exmem_write(s_exmem_write), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .memwb_flush(s_memwb_flush), .mem_timeout(s_mem_timeout),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the instruction sitting in EX, run length of busy cycles, raw event tallies
    bit       m_ex_valid, m_ex_load;
    int       m_ex_dst;
    int       m_busy_run;
    bit       m_halted;
    int       m_stalls, m_flushes;
    // Expected controls: bits {pc,ifid,idex,exmem writes, ifid,idex,memwb flushes}
    bit [6:0] e_ctl;
    int       e_case;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_valid = 0; m_ex_load = 0; m_ex_dst = 0;
        m_busy_run = 0; m_halted = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_outputs();
        bit hazard;
        hazard = id_valid && m_ex_valid && m_ex_load && m_ex_dst != 0 &&
                 ((id_uses_rs && int'(id_rs) == m_ex_dst) ||
                  (id_uses_rt && int'(id_rt) == m_ex_dst));
        if (!rst_n)                              begin e_case = 0; e_ctl = 7'b0000111; end
        else if (m_halted || dmem_busy)          begin e_case = 1; e_ctl = 7'b0000001; end
        else if (m_ex_valid && ex_branch_taken)  begin e_case = 2; e_ctl = 7'b1111110; end
        else if (hazard)                         begin e_case = 3; e_ctl = 7'b0011010; end
        else if (id_valid && id_jump)            begin e_case = 4; e_ctl = 7'b1111100; end
        else                                     begin e_case = 5; e_ctl = 7'b1111000; end
    endtask

    task automatic compare_all();
        bit [6:0] act, sact;
        model_outputs();
        act  = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
                memwb_flush};
        sact = {s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_ifid_flush,
                s_idex_flush, s_memwb_flush};
        check("controls", int'(act), int'(e_ctl));
        check("controls_small", int'(sact), int'(e_ctl));
        check("mem_timeout", int'(mem_timeout), int'(m_halted));
        check("mem_timeout_small", int'(s_mem_timeout), int'(m_halted));
        check("stall_count", int'(stall_count), sat(m_stalls, 65535));
        check("flush_count", int'(flush_count), sat(m_flushes, 65535));
        check("stall_count_small", int'(s_stall_count), sat(m_stalls, 15));
        check("flush_count_small", int'(s_flush_count), sat(m_flushes, 15));
    endtask

    // Called after inputs change (at the falling edge)
    task automatic settle();
        if (!rst_n) model_reset();
        #1;
        compare_all();
    endtask

    // Advance one rising edge, then return at the next falling edge
    task automatic tick();
        bit nv, nl, nh;
        int nd, nb;
        nv = m_ex_valid; nl = m_ex_load; nd = m_ex_dst; nh = m_halted; nb = m_busy_run;
        if (rst_n) begin
            if (e_ctl[6] == 0 && !m_halted) m_stalls++;
            if (e_case == 2 || e_case == 4) m_flushes++;
            if (e_ctl[4]) begin
                nv = id_valid && !e_ctl[1];
                nl = id_memread;
                nd = int'(id_dst);
            end
            if (!m_halted) begin
                nb = dmem_busy ? m_busy_run + 1 : 0;
                if (nb >= MT) nh = 1;
            end
        end
        @(posedge clk);
        m_ex_valid = nv; m_ex_load = nl; m_ex_dst = nd; m_halted = nh; m_busy_run = nb;
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_memread = 0; id_dst = 0; id_jump = 0; ex_branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic instr(input bit ld, input int rs, input int dst, input bit jmp);
        idle();
        id_valid = 1; id_memread = ld; id_rs = 5'(rs); id_uses_rs = (rs != 0);
        id_dst = 5'(dst); id_jump = jmp;
    endtask

    int burst;

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        @(negedge clk);
        settle();
        check("rst_pc_write", int'(pc_write), 0);
        check("rst_flushes", int'({ifid_flush, idex_flush, memwb_flush}), 7);
        tick();

        rst_n = 1; idle(); settle();
        check("idle_writes", int'({pc_write, ifid_write, idex_write, exmem_write}), 15);
        check("idle_flushes", int'({ifid_flush, idex_flush, memwb_flush}), 0);
        tick();

        // lw $t0 then dependent add
        instr(1, 0, 8, 0); settle(); tick();
        instr(0, 8, 9, 0); settle();
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_idex_flush", int'(idex_flush), 1);
        tick();
        settle();
        check("lu_cleared", int'(pc_write), 1);
        check("lu_stall_count", int'(stall_count), 1);
        tick();

        // Load in EX, dependent in ID, branch taken wins
        instr(1, 0, 10, 0); settle(); tick();
        instr(0, 10, 11, 0); ex_branch_taken = 1; settle();
        check("br_flushes", int'({ifid_flush, idex_flush}), 3);
        check("br_pc_write", int'(pc_write), 1);
        tick();
        idle(); settle();
        check("br_flush_count", int'(flush_count), 1);
        check("br_stall_count", int'(stall_count), 1);
        tick();

        // Three-cycle memory freeze
        for (int i = 0; i < 3; i++) begin
            idle(); dmem_busy = 1; settle();
            check("busy_memwb_flush", int'(memwb_flush), 1);
            tick();
        end
        idle(); settle();
        check("busy_release_pc", int'(pc_write), 1);
        check("busy_stall_count", int'(stall_count), 4);
        tick();

        // Timeout into halt
        for (int i = 0; i < MT; i++) begin
            idle(); dmem_busy = 1; settle(); tick();
        end
        idle(); settle();
        check("halt_sticky", int'(mem_timeout), 1);
        check("halt_stall_count", int'(stall_count), 4 + MT);
        tick();
        settle();
        check("halt_stall_frozen", int'(stall_count), 4 + MT);
        rst_n = 0; settle();
        check("halt_reset_clears", int'(mem_timeout), 0);
        tick();
        rst_n = 1; idle(); settle(); tick();

        // Jumps saturate the narrow flush counter
        for (int i = 0; i < 20; i++) begin
            instr(0, 0, 0, 1); settle(); tick();
        end
        idle(); settle();
        check("jump_sat_small", int'(s_flush_count), 15);
        check("jump_count_wide", int'(flush_count), 20);
        tick();

        // Randomized traffic
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_dst = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_memread = ($urandom_range(0, 2) == 0);
            id_jump = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 249) == 0) burst = $urandom_range(MT - 1, MT + 2);
            dmem_busy = (burst > 0) || ($urandom_range(0, 9) == 0);
            if (burst > 0) burst--;
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the 5-stage pipelined processor: it sits beside the main opcode decoder and drives the stage-register write enables and flush (bubble) controls. It detects load-use hazards against a private shadow of the ID/EX stage and flushes wrong-path instructions on jumps and taken branches. It freezes the whole pipeline while data memory is busy, enters a sticky halt on memory timeout, and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 16, consecutive dmem_busy cycles that trigger HALT (≥2)
- CNT_W, 16, width of performance counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  5  ID source register numbers
- id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt
- id_memread  in  1  ID instruction is a load (decoder MemRead)
- id_dst  in  5  ID destination after RegDst mux
- id_jump  in  1  decoder jump
- ex_branch_taken  in  1  EX branch resolved taken (Branch & zero)
- dmem_busy  in  1  data memory access in MEM not complete
- pc_write, ifid_write, idex_write, exmem_write  out  1  stage register enables
- ifid_flush, idex_flush, memwb_flush  out  1  load bubble into IF/ID, ID/EX, MEM/WB
- mem_timeout  out  1  sticky halt indicator
- stall_count, flush_count  out  CNT_W  saturating counters

## Operation
- Shadow regs ex_valid, ex_memread, ex_dst: on edge with idex_write=1 load id_valid & ~idex_flush, id_memread, id_dst; else hold. Reset: all 0.
- load_use = id_valid & ex_valid & ex_memread & (ex_dst≠0) & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- taken = ex_valid & ex_branch_taken.
- FSM states RUN, MEM_WAIT, HALT; wait_cnt counts busy cycles.
  - RUN: dmem_busy → MEM_WAIT, wait_cnt←1.
  - MEM_WAIT: ~dmem_busy → RUN, wait_cnt←0; dmem_busy & wait_cnt==MEM_TIMEOUT-1 → HALT; else wait_cnt++.
  - HALT: terminal until rst_n low; mem_timeout=1.
- Output priority (combinational, from state, shadow, inputs):
  1. HALT, or dmem_busy in any state: all four writes 0, ifid_flush=idex_flush=0, memwb_flush=1.
  2. taken: all writes 1, ifid_flush=idex_flush=1 (load_use, id_jump ignored).
  3. load_use: pc_write=ifid_write=0, idex_write=exmem_write=1, idex_flush=1.
  4. id_valid & id_jump: all writes 1, ifid_flush=1.
  5. default: all writes 1, all flushes 0.
- memwb_flush=0 outside case 1.
- stall_count +1 per cycle with pc_write=0 and state≠HALT; flush_count +1 per cycle in case 2 or 4; both saturate at all-ones.

## Timing
- While rst_n low: writes 0, all three flushes 1, counters 0, mem_timeout 0, state RUN; release takes effect at first clk edge after deassertion.
- Control outputs are combinational, same cycle as inputs; state, shadow, counters update on rising edge.
- Load-use stall is exactly one cycle: bubble enters shadow, so load_use drops next cycle.
- Taken-branch penalty two slots, jump one slot.
- Freeze begins the same cycle dmem_busy rises, ends the cycle it falls; EX is frozen, so a pending taken branch is applied the first unfrozen cycle.
- dmem_busy high MEM_TIMEOUT consecutive cycles → HALT on that edge; busy for MEM_TIMEOUT-1 cycles then low → RUN, no halt.
- Reset mid-MEM_WAIT or HALT returns to RUN with cleared shadow and counters.

## Test plan
- Reset, then idle inputs: all writes 1, flushes 0, counters 0, mem_timeout 0.
- lw $t0 (id_dst=8, id_memread) then add using rs=8: one cycle pc_write=ifid_write=0, idex_flush=1; next cycle normal; stall_count=1.
- Load in EX with dependent in ID plus ex_branch_taken=1: ifid_flush=idex_flush=1, pc_write=1, no stall; flush_count=1.
- dmem_busy high 3 cycles with MEM_TIMEOUT=16: writes 0, memwb_flush=1 for exactly 3 cycles; stall_count=3; state back to RUN.
- dmem_busy held 16 cycles: HALT at 16th edge, mem_timeout=1 sticky after busy drops; stall_count frozen; rst_n pulse clears.
- CNT_W=4, 20 jump cycles: flush_count saturates at 15.
